// File: rtl/scc_slot_initiator.sv
// MSX cartridge-slot front end for the SCC register block.
// Synchronises slot strobes into request pulses, windows and read drive.
module scc_slot_initiator #(
  parameter int unsigned READ_LATENCY = 3,
  parameter bit          USE_WAIT     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slot_nsltsl,
  input  logic        slot_nrd,
  input  logic        slot_nwr,
  input  logic [15:0] slot_a,
  input  logic [7:0]  slot_d_in,
  output logic [7:0]  slot_d_out,
  output logic        slot_d_oe,
  output logic        slot_nwait,
  output logic        wrreq,
  output logic        rdreq,
  output logic        wr_active,
  output logic        rd_active,
  output logic [14:0] address,
  output logic [7:0]  wrdata,
  input  logic [7:0]  rddata,
  input  logic        ext_memory_nactive
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_WAIT,
    READ_DRIVE,
    RELEASE
  } state_t;

  localparam logic [3:0] LAT = 4'(READ_LATENCY);
  localparam logic WAIT_LVL = !USE_WAIT;

  state_t      state, state_n;
  logic [1:0]  sl_sync, rd_sync, wr_sync;
  logic        rd_prev, wr_prev;
  logic [3:0]  count, count_n;
  logic        nsl, nrd, nwr;
  logic        rd_fall, wr_fall;
  logic        valid, rd_done, wr_done;

  logic        wrreq_n, rdreq_n;
  logic        wr_active_n, rd_active_n;
  logic        oe_n, nwait_n;
  logic [7:0]  d_out_n, wrdata_n;
  logic [14:0] address_n;

  // Syncs reset low: a strobe held across reset needs a fresh high first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sl_sync <= '0;
      rd_sync <= '0;
      wr_sync <= '0;
      rd_prev <= 1'b0;
      wr_prev <= 1'b0;
    end else begin
      sl_sync <= {sl_sync[0], slot_nsltsl};
      rd_sync <= {rd_sync[0], slot_nrd};
      wr_sync <= {wr_sync[0], slot_nwr};
      rd_prev <= rd_sync[1];
      wr_prev <= wr_sync[1];
    end
  end

  assign nsl     = sl_sync[1];
  assign nrd     = rd_sync[1];
  assign nwr     = wr_sync[1];
  assign rd_fall = !nrd && rd_prev;
  assign wr_fall = !nwr && wr_prev;
  assign valid   = !nsl &&
                   (slot_a[15:14] == 2'b01 ||
                    slot_a[15:14] == 2'b10);
  assign rd_done = nrd || nsl;
  assign wr_done = nwr || nsl;

  always_comb begin
    state_n     = state;
    count_n     = count;
    wrreq_n     = 1'b0;
    rdreq_n     = 1'b0;
    wr_active_n = wr_active;
    rd_active_n = rd_active;
    oe_n        = slot_d_oe;
    nwait_n     = slot_nwait;
    d_out_n     = slot_d_out;
    wrdata_n    = wrdata;
    address_n   = address;
    unique case (state)
      IDLE: begin
        if (valid && (rd_fall || wr_fall)) begin
          if (!nrd && !nwr) begin
            state_n = RELEASE;
          end else if (wr_fall) begin
            address_n   = slot_a[14:0];
            wrdata_n    = slot_d_in;
            wrreq_n     = 1'b1;
            wr_active_n = 1'b1;
            state_n     = WRITE;
          end else begin
            address_n   = slot_a[14:0];
            rdreq_n     = 1'b1;
            rd_active_n = 1'b1;
            nwait_n     = WAIT_LVL;
            count_n     = LAT;
            state_n     = READ_WAIT;
          end
        end
      end
      WRITE: begin
        if (wr_done) begin
          wr_active_n = 1'b0;
          state_n     = IDLE;
        end
      end
      READ_WAIT: begin
        if (rd_done) begin
          rd_active_n = 1'b0;
          nwait_n     = 1'b1;
          state_n     = IDLE;
        end else begin
          count_n = count - 4'd1;
          if (count == 4'd1) begin
            d_out_n = rddata;
            oe_n    = ext_memory_nactive;
            nwait_n = 1'b1;
            state_n = READ_DRIVE;
          end
        end
      end
      READ_DRIVE: begin
        if (rd_done) begin
          rd_active_n = 1'b0;
          oe_n        = 1'b0;
          state_n     = IDLE;
        end
      end
      RELEASE: begin
        if (nrd && nwr) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      wrreq      <= 1'b0;
      rdreq      <= 1'b0;
      wr_active  <= 1'b0;
      rd_active  <= 1'b0;
      slot_d_oe  <= 1'b0;
      slot_nwait <= 1'b1;
      slot_d_out <= '0;
      wrdata     <= '0;
      address    <= '0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      wrreq      <= wrreq_n;
      rdreq      <= rdreq_n;
      wr_active  <= wr_active_n;
      rd_active  <= rd_active_n;
      slot_d_oe  <= oe_n;
      slot_nwait <= nwait_n;
      slot_d_out <= d_out_n;
      wrdata     <= wrdata_n;
      address    <= address_n;
    end
  end

endmodule

// File: tb/tb_scc_slot_initiator.sv
// Scoreboard bench for scc_slot_initiator: random slot accesses
// against a cycle-count model of the slot protocol.
module tb_scc_slot_initiator;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        slot_nsltsl = 1'b1;
  logic        slot_nrd = 1'b1;
  logic        slot_nwr = 1'b1;
  logic [15:0] slot_a = '0;
  logic [7:0]  slot_d_in = '0;
  logic [7:0]  slot_d_out;
  logic        slot_d_oe;
  logic        slot_nwait;
  logic        wrreq, rdreq, wr_active, rd_active;
  logic [14:0] address;
  logic [7:0]  wrdata;
  logic [7:0]  rddata = '0;
  logic        ext_memory_nactive = 1'b1;

  scc_slot_initiator #(.READ_LATENCY(LAT), .USE_WAIT(1'b1)) dut (
    .clk(clk), .reset(reset),
    .slot_nsltsl(slot_nsltsl), .slot_nrd(slot_nrd),
    .slot_nwr(slot_nwr), .slot_a(slot_a),
    .slot_d_in(slot_d_in), .slot_d_out(slot_d_out),
    .slot_d_oe(slot_d_oe), .slot_nwait(slot_nwait),
    .wrreq(wrreq), .rdreq(rdreq),
    .wr_active(wr_active), .rd_active(rd_active),
    .address(address), .wrdata(wrdata),
    .rddata(rddata), .ext_memory_nactive(ext_memory_nactive)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    logic [14:0] a;
    logic [7:0]  d;
    int          h;
    int          nw;
    int          oe;
    logic [7:0]  dout;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          stray = 0;
  int          bad = 0;
  logic [7:0]  last_dout = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // Model: expected window lengths follow from hold time h vs latency
  task automatic access(input bit wr, input bit rd,
                        input logic [15:0] a, input logic [7:0] d,
                        input int h, input bit ext,
                        input logic [7:0] rdv, input int gap);
    exp_t e;
    bit   inwin, cap;
    inwin = (a[15:14] == 2'b01) || (a[15:14] == 2'b10);
    if (inwin && (wr ^ rd)) begin
      cap    = rd && (h > LAT);
      e.w    = wr;
      e.a    = a[14:0];
      e.d    = d;
      e.h    = h;
      e.nw   = rd ? ((h < LAT) ? h : LAT) : 0;
      e.oe   = (cap && ext) ? h - LAT : 0;
      e.dout = cap ? rdv : last_dout;
      if (cap) last_dout = rdv;
      q.push_back(e);
    end
    @(negedge clk);
    slot_a = a;
    slot_d_in = d;
    rddata = rdv;
    ext_memory_nactive = ext;
    slot_nsltsl = 1'b0;
    slot_nrd = ~rd;
    slot_nwr = ~wr;
    repeat (h) @(negedge clk);
    slot_nsltsl = 1'b1;
    slot_nrd = 1'b1;
    slot_nwr = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  bit          in_txn = 0;
  bit          t_w;
  int          t_cyc, t_pul, t_nw, t_oe;
  logic [14:0] t_a;
  logic [7:0]  t_d;

  task automatic finish_txn();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_txn: got a transaction, expected none");
      return;
    end
    e = q.pop_front();
    chk("kind_write", int'(t_w), int'(e.w));
    chk("pulse_count", t_pul, 1);
    chk("address", int'(t_a), int'(e.a));
    if (e.w) chk("wrdata", int'(t_d), int'(e.d));
    chk("active_cycles", t_cyc, e.h);
    chk("nwait_low_cycles", t_nw, e.nw);
    chk("oe_cycles", t_oe, e.oe);
    chk("d_out", int'(slot_d_out), int'(e.dout));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_txn = 0;
    end else if (rd_active || wr_active) begin
      if (!in_txn) begin
        in_txn = 1;
        t_w = 0;
        t_cyc = 0;
        t_pul = 0;
        t_nw = 0;
        t_oe = 0;
      end
      t_cyc++;
      if (wrreq) begin
        t_pul++;
        t_w = 1;
        t_a = address;
        t_d = wrdata;
      end
      if (rdreq) begin
        t_pul++;
        t_a = address;
      end
      if (!slot_nwait) t_nw++;
      if (slot_d_oe) t_oe++;
      if ((rdreq && wrreq) || (rd_active && wr_active)) bad++;
    end else begin
      if (in_txn) begin
        in_txn = 0;
        finish_txn();
      end
      if (wrreq || rdreq || !slot_nwait || slot_d_oe) stray++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_nwait", int'(slot_nwait), 1);
    chk("reset_oe", int'(slot_d_oe), 0);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);

    access(1, 0, 16'h9880, 8'h5A, 8, 1, 8'h00, 3);
    access(0, 1, 16'h9800, 8'h00, 12, 1, 8'hA5, 3);
    access(0, 1, 16'h9800, 8'h00, 12, 0, 8'h3C, 3);
    access(0, 1, 16'h4123, 8'h00, 2, 1, 8'h77, 3);
    access(1, 0, 16'h4ABC, 8'hC3, 4, 1, 8'h00, 3);
    access(1, 0, 16'h2000, 8'h11, 6, 1, 8'h00, 3);
    access(1, 1, 16'h9000, 8'h22, 6, 1, 8'h44, 3);
    access(0, 1, 16'hC000, 8'h00, 8, 1, 8'h99, 3);
    access(0, 1, 16'h5555, 8'h00, LAT + 1, 1, 8'hE1, 2);

    for (int i = 0; i < 60; i++) begin
      int          k;
      logic [15:0] a;
      k = $urandom_range(0, 9);
      if (k == 8)
        a = {($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00,
             14'($urandom)};
      else
        a = {2'($urandom_range(1, 2)), 14'($urandom)};
      access(k < 4 || k >= 8 ? 1'b1 : 1'b0,
             (k >= 4 && k < 8) || k == 9 ? 1'b1 : 1'b0,
             a, 8'($urandom), $urandom_range(2, 10),
             1'($urandom), 8'($urandom), $urandom_range(2, 4));
    end

    @(negedge clk);
    slot_a = 16'h8123;
    rddata = 8'h3C;
    ext_memory_nactive = 1'b1;
    slot_nsltsl = 1'b0;
    slot_nrd = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_wrreq", int'(wrreq), 0);
    chk("rst_rdreq", int'(rdreq), 0);
    chk("rst_wr_active", int'(wr_active), 0);
    chk("rst_rd_active", int'(rd_active), 0);
    chk("rst_address", int'(address), 0);
    chk("rst_wrdata", int'(wrdata), 0);
    chk("rst_d_out", int'(slot_d_out), 0);
    chk("rst_oe", int'(slot_d_oe), 0);
    chk("rst_nwait", int'(slot_nwait), 1);
    last_dout = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdreq || rd_active) cnt++;
    end
    chk("no_reissue_after_reset", cnt, 0);
    slot_nsltsl = 1'b1;
    slot_nrd = 1'b1;
    repeat (3) @(negedge clk);
    access(0, 1, 16'h8123, 8'h00, 9, 1, 8'h6B, 3);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("pending_expected", q.size(), 0);
    chk("stray_outputs", stray, 0);
    chk("overlap_or_dual_pulse", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
